dmem_responder: RTL

Responder end of the CPU data-memory port: accepts load/store requests from the core over a valid/ready handshake, holds them for a configurable number of wait states, commits byte-enabled writes to a word-addressed array, and returns a one-cycle response. It stands in place of the zero-latency data memory when the core is built with a stall-capable data port. It exercises the core's memory-stall path.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_array.sv | 42 ++++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane writes; the output register captures the
// post-merge word on every enabled access and holds it otherwise.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BE_W-1:0]   we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= merged;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Stall-capable data-memory responder: accept, wait LATENCY cycles, commit, one-cycle response.
// Optional misalignment check under `DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BE_W-1:0]   req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);
    localparam bit               ZERO_LAT = (LATENCY == 0);

    dmem_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] idx_q;
    logic [BE_W-1:0]   we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              commit;
    logic              mis_c;
    logic              arr_en;
    logic [ADDR_W-1:0] c_idx;
    logic [BE_W-1:0]   c_we;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_INIT;
                    commit    = ZERO_LAT;
                end
            end
            WAIT: begin
                // The cycle after the counter hits zero lets the registered read settle.
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    commit  = (cnt == CNT_W'(1));
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q   <= req_addr[ADDR_W+1:2];
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
        end
    end

    // With zero latency the commit happens on the acceptance edge, so use live inputs.
    assign c_idx   = ZERO_LAT ? req_addr[ADDR_W+1:2] : idx_q;
    assign c_we    = ZERO_LAT ? req_we : we_q;
    assign c_wdata = ZERO_LAT ? req_wdata : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;
    logic err_q;
    logic unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign mis_c       = ZERO_LAT ? (req_addr[1:0] != 2'b00) : mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                mis_q <= (req_addr[1:0] != 2'b00);
            end
            if (commit) begin
                err_q <= mis_c;
            end
        end
    end

    assign rsp_err   = err_q;
    assign rsp_rdata = err_q ? '0 : arr_rdata;
`else
    logic unused_addr;

    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign mis_c       = 1'b0;
    assign rsp_err     = 1'b0;
    assign rsp_rdata   = arr_rdata;
`endif

    assign arr_en = commit & ~mis_c;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (arr_en),
        .we    (c_we),
        .idx   (c_idx),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );
endmodule
